// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
//
// Shares the single eth_mac TX AXI-stream byte port between NUM_PORTS packet
// sources. Round-robin arbitration at packet granularity: once a port is
// granted it keeps the output until its tlast byte has handshaken. The port
// that just finished drops to the lowest priority for the next round.
// Lives entirely in the clk_mac domain.
//
// Parameters
//   NUM_PORTS    number of requesters, 2..8
//   IFG_CYCLES   idle cycles forced between packets (ETH_TX_ARB_IFG_EN only)
//
// Configuration macro
//   ETH_TX_ARB_IFG_EN  when defined, an inter-frame gap state holds the output
//                      idle for IFG_CYCLES cycles after every packet.
//                      IFG_CYCLES=0 behaves as if the macro were undefined.
//
// Ports
//   clk_mac        MAC clock, the only clock
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   requester bytes, port k on [8k+7:8k]
//   s_axis_tvalid  per-port valid (also the arbitration request)
//   s_axis_tlast   per-port end of packet
//   s_axis_tready  per-port ready, only the granted bit can be 1
//   m_axis_tdata   to tx_axis_mac_tdata
//   m_axis_tvalid  to tx_axis_mac_tvalid
//   m_axis_tlast   to tx_axis_mac_tlast
//   m_axis_tready  from tx_axis_mac_tready
//   grant_idx      current / last granted port
//   busy           1 whenever not idle (packet or gap in progress)
//   pkt_done       one-cycle pulse after each tlast handshake
// ---------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int IFG_CYCLES = 12
) (
    input  logic                         clk_mac,
    input  logic                         rst_n,
    input  logic [NUM_PORTS*8-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]         s_axis_tlast,
    output logic [NUM_PORTS-1:0]         s_axis_tready,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         busy,
    output logic                         pkt_done
);

    localparam int          IW   = $clog2(NUM_PORTS);
    // One extra bit so rr_ptr + offset can exceed NUM_PORTS-1 before wrapping.
    localparam logic [IW:0] NP_W = (IW + 1)'(NUM_PORTS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PKT  = 2'd1;
`ifdef ETH_TX_ARB_IFG_EN
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam bit                GAP_EN   = (IFG_CYCLES > 0);
    localparam int                CW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CW-1:0]     GAP_LOAD = CW'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

    logic [CW-1:0] gap_cnt;
`endif

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] rr_next;
    logic          req_any;
    logic          in_pkt;
    logic          tlast_hs;

    // ------------------------------------------------------------------
    // Round-robin search: scan rr_ptr, rr_ptr+1, ... wrapping at NUM_PORTS
    // (not at 2^IW) so non-power-of-two port counts never select a
    // nonexistent port. The first hit is kept.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IW:0] idx;
        winner  = rr_ptr;
        req_any = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_ptr} + (IW + 1)'(i);
            if (idx >= NP_W) begin
                idx = idx - NP_W;
            end
            if (!req_any && s_axis_tvalid[idx[IW-1:0]]) begin
                req_any = 1'b1;
                winner  = idx[IW-1:0];
            end
        end
    end

    assign rr_next = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + IW'(1);

    // ------------------------------------------------------------------
    // Datapath: purely combinational mux from the granted port, forced
    // to zero outside ST_PKT so the MAC sees nothing during arbitration,
    // gap or reset.
    // ------------------------------------------------------------------
    assign in_pkt        = (state == ST_PKT);
    assign m_axis_tvalid = in_pkt & s_axis_tvalid[grant_idx];
    assign m_axis_tlast  = in_pkt & s_axis_tlast[grant_idx];
    assign m_axis_tdata  = in_pkt ? s_axis_tdata[{grant_idx, 3'b000} +: 8] : '0;
    assign tlast_hs      = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign busy          = (state != ST_IDLE);

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            s_axis_tready[i] = in_pkt & m_axis_tready & (grant_idx == IW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            pkt_done  <= 1'b0;
`ifdef ETH_TX_ARB_IFG_EN
            gap_cnt   <= '0;
`endif
        end else begin
            pkt_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        grant_idx <= winner;
                        state     <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    // Grant is locked until tlast handshakes; a stalled
                    // source simply holds m_axis_tvalid low.
                    if (tlast_hs) begin
                        pkt_done <= 1'b1;
                        rr_ptr   <= rr_next;
`ifdef ETH_TX_ARB_IFG_EN
                        if (GAP_EN) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state   <= ST_IDLE;
                        end
`else
                        state    <= ST_IDLE;
`endif
                    end
                end
`ifdef ETH_TX_ARB_IFG_EN
                ST_GAP: begin
                    // Loaded with IFG_CYCLES-1 and left on zero: the state
                    // lasts exactly IFG_CYCLES cycles.
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - CW'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_arbiter
//
// Randomised scoreboard bench. Packets are queued per source; the expected
// bytes go to per-port scoreboard queues at issue time. A monitor pops and
// compares on every output handshake, predicting the granted port from the
// round-robin rule over the ports that still have queued packets.
// A second, 3-port instance checks non-power-of-two wrapping.
// ---------------------------------------------------------------------------
module tb_eth_tx_arbiter;

    localparam int NP = 4;
`ifdef ETH_TX_ARB_IFG_EN
    localparam int GAP_N = 12;
`else
    localparam int GAP_N = 0;
`endif

    typedef logic [8:0] beat_t;   // {tlast, tdata}

    logic              clk_mac = 1'b0;
    logic              rst_n;
    logic [NP*8-1:0]   s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [7:0]        m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              pkt_done;

    logic [23:0]       s3_tdata;
    logic [2:0]        s3_tvalid;
    logic [2:0]        s3_tlast;
    logic [2:0]        s3_tready;
    logic [7:0]        m3_tdata;
    logic              m3_tvalid;
    logic              m3_tlast;
    logic              m3_tready;
    logic [1:0]        grant3;
    logic              busy3;
    logic              done3;

    eth_tx_arbiter #(.NUM_PORTS(NP), .IFG_CYCLES(12)) u_dut (
        .clk_mac       (clk_mac),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .pkt_done      (pkt_done)
    );

    eth_tx_arbiter #(.NUM_PORTS(3), .IFG_CYCLES(12)) u_dut3 (
        .clk_mac       (clk_mac),
        .rst_n         (rst_n),
        .s_axis_tdata  (s3_tdata),
        .s_axis_tvalid (s3_tvalid),
        .s_axis_tlast  (s3_tlast),
        .s_axis_tready (s3_tready),
        .m_axis_tdata  (m3_tdata),
        .m_axis_tvalid (m3_tvalid),
        .m_axis_tlast  (m3_tlast),
        .m_axis_tready (m3_tready),
        .grant_idx     (grant3),
        .busy          (busy3),
        .pkt_done      (done3)
    );

    initial forever #5 clk_mac = ~clk_mac;

    // ---------------- bench state ----------------
    int    n_checks = 0;
    int    n_errors = 0;

    beat_t src_q [NP][$];   // what each source still has to send
    beat_t exp_q [NP][$];   // scoreboard: what the MAC side must see
    int    grant_log [$];

    // reference model state
    bit    in_pkt_m = 1'b0;
    int    cur_port = 0;
    int    m_rr = 0;
    bit    done_next = 1'b0;
    int    since_last = 100000;
    int    mcyc = 0;
    int    last_tlast_cyc = -1;
    bit    spacing_chk = 1'b0;
    int    spacing_seen = 0;
    int    hs_total = 0;
    int    pkt_cnt = 0;

    // source behaviour
    bit    tready_rand = 1'b0;
    int    sent [NP];
    int    stall_port = -1;
    int    stall_at = 0;
    int    stall_len = 0;
    int    stall_rem = 0;
    bit    stall_done = 1'b0;

    int    t6_exp [5] = '{0, 3, 0, 3, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int model_pick();
        int p;
        for (int i = 0; i < NP; i++) begin
            p = (m_rr + i) % NP;
            if (exp_q[p].size() != 0) return p;
        end
        return -1;
    endfunction

    function automatic int pending_count();
        int n = int'(in_pkt_m);
        for (int k = 0; k < NP; k++) n += exp_q[k].size();
        return n;
    endfunction

    task automatic issue(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), 8'($urandom)};
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < NP; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        in_pkt_m       = 1'b0;
        m_rr           = 0;
        done_next      = 1'b0;
        since_last     = 100000;
        last_tlast_cyc = -1;
        stall_rem      = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tlast"},  m_tlast, 0);
        chk({tag, "_m_tdata"},  m_tdata, 0);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
        chk({tag, "_grant"},    grant_idx, 0);
        chk({tag, "_busy3"},    busy3, 0);
        chk({tag, "_done3"},    done3, 0);
        chk({tag, "_grant3"},   grant3, 0);
    endtask

    task automatic do_reset();
        @(posedge clk_mac); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        flush_model();
        repeat (2) @(posedge clk_mac);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int c = 0;
        while (pending_count() != 0 && c < 4000) begin
            @(posedge clk_mac);
            c++;
        end
        chk("drain_left", pending_count(), 0);
        if (pending_count() != 0) flush_model();
        repeat (GAP_N + 4) @(posedge clk_mac);
        #3;
    endtask

    // ---------------- source driver ----------------
    initial begin : driver
        logic [NP-1:0] hs_s;
        forever begin
            @(negedge clk_mac);
            hs_s = s_tvalid & s_tready;
            @(posedge clk_mac);
            #1;
            for (int k = 0; k < NP; k++) begin
                if (hs_s[k] && src_q[k].size() != 0) begin
                    src_q[k].delete(0);
                    sent[k]++;
                    if (k == stall_port && sent[k] == stall_at && !stall_done) begin
                        stall_rem  = stall_len;
                        stall_done = 1'b1;
                    end
                end
                if (k == stall_port && stall_rem > 0) begin
                    s_tvalid[k] = 1'b0;
                    stall_rem--;
                end else if (src_q[k].size() != 0) begin
                    s_tvalid[k]         = 1'b1;
                    s_tdata[k*8 +: 8]   = src_q[k][0][7:0];
                    s_tlast[k]          = src_q[k][0][8];
                end else begin
                    s_tvalid[k]         = 1'b0;
                    s_tlast[k]          = 1'b0;
                    s_tdata[k*8 +: 8]   = '0;
                end
            end
            m_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        beat_t         b;
        int            p;
        bit            exp_done;
        logic [NP-1:0] oh;
        forever begin
            @(negedge clk_mac);
            if (rst_n) begin
                mcyc++;
                if (since_last < 100000) since_last++;
                exp_done  = done_next;
                done_next = 1'b0;
                if (pkt_done) pkt_cnt++;
                if (exp_done || pkt_done) chk("pkt_done", pkt_done, exp_done);
                if (since_last >= 1 && since_last <= GAP_N) begin
                    chk("gap_busy", busy, 1);
                    chk("gap_m_tvalid", m_tvalid, 0);
                    chk("gap_s_tready", s_tready, 0);
                end
                if (since_last == GAP_N + 1) chk("arb_busy", busy, 0);
                if (in_pkt_m) begin
                    oh = m_tready ? (NP'(1) << cur_port) : '0;
                    chk("s_tready_grant", s_tready, oh);
                end
                if (m_tvalid && m_tready) begin
                    if (!in_pkt_m) begin
                        p = model_pick();
                        if (p < 0) begin
                            chk("unexpected_byte_port", grant_idx, 4);
                        end else begin
                            chk("grant_idx", grant_idx, p);
                            grant_log.push_back(int'(grant_idx));
                            cur_port = p;
                            in_pkt_m = 1'b1;
                            if (spacing_chk && last_tlast_cyc >= 0) begin
                                chk("pkt_spacing", mcyc - last_tlast_cyc, GAP_N + 2);
                                spacing_seen++;
                            end
                        end
                    end
                    if (in_pkt_m) begin
                        b = exp_q[cur_port].pop_front();
                        chk("byte", {m_tlast, m_tdata}, b);
                        hs_total++;
                        if (b[8]) begin
                            in_pkt_m       = 1'b0;
                            m_rr           = (cur_port + 1) % NP;
                            done_next      = 1'b1;
                            since_last     = 0;
                            last_tlast_cyc = mcyc;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- test sequence ----------------
    initial begin : main
        int c;
        int pulses0;
        int cnt3 [3];
        int ep;
        bit st;
        int npk;
        logic [2:0] oh3;
        logic [8:0] e3;

        rst_n     = 1'b0;
        s_tdata   = '0;
        s_tvalid  = '0;
        s_tlast   = '0;
        m_tready  = 1'b1;
        s3_tdata  = '0;
        s3_tvalid = '0;
        s3_tlast  = '0;
        m3_tready = 1'b0;
        for (int k = 0; k < NP; k++) sent[k] = 0;

        // 1: port 2 alone, 64 bytes
        do_reset();
        grant_log.delete();
        pulses0 = pkt_cnt;
        issue(2, 64);
        drain();
        chk("t1_npkts", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("t1_grant", grant_log[0], 2);
        chk("t1_pulses", pkt_cnt - pulses0, 1);
        chk("t1_busy_after", busy, 0);

        // 2: all four ports, 3 x 10 bytes each
        do_reset();
        grant_log.delete();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < NP; p++) issue(p, 10);
        drain();
        chk("t2_npkts", grant_log.size(), 12);
        for (int i = 0; i < grant_log.size(); i++) chk("t2_order", grant_log[i], i % 4);

        // back-to-back spacing, single requester and 1-byte packets
        do_reset();
        grant_log.delete();
        spacing_seen = 0;
        spacing_chk  = 1'b1;
        issue(0, 6);
        issue(0, 6);
        for (int i = 0; i < 3; i++) issue(3, 1);
        drain();
        spacing_chk = 1'b0;
        chk("t6_spacing_count", spacing_seen, 4);
        chk("t6_npkts", grant_log.size(), 5);
        for (int i = 0; i < grant_log.size() && i < 5; i++) chk("t6_order", grant_log[i], t6_exp[i]);

        // 3: random traffic, random m_tready, 5-cycle mid-packet stall
        for (int k = 0; k < NP; k++) sent[k] = 0;
        stall_port  = 1;
        stall_at    = 5;
        stall_len   = 5;
        stall_done  = 1'b0;
        tready_rand = 1'b1;
        issue(1, 12);
        for (int i = 0; i < 11; i++) issue(int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 16)));
        drain();
        tready_rand = 1'b0;
        chk("t3_stall_happened", stall_done, 1);
        stall_port = -1;

        // 4: reset during byte 20 of a packet
        do_reset();
        hs_total = 0;
        issue(3, 40);
        c = 0;
        while (hs_total < 20 && c < 500) begin
            @(posedge clk_mac);
            c++;
        end
        chk("t4_reached_byte20", hs_total, 20);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4");
        flush_model();
        repeat (2) @(posedge clk_mac);
        #3;
        rst_n = 1'b1;
        grant_log.delete();
        issue(3, 5);
        issue(0, 5);
        drain();
        chk("t4_npkts", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("t4_first_grant", grant_log[0], 0);

        // 5: three-port instance, ports 1 and 2 always requesting
        for (int k = 0; k < 3; k++) cnt3[k] = 0;
        ep  = 1;
        st  = 1'b1;
        npk = 0;
        for (int k = 1; k < 3; k++) begin
            s3_tdata[k*8 +: 8] = 8'(k * 16);
            s3_tlast[k]        = 1'b0;
        end
        s3_tvalid = 3'b110;
        m3_tready = 1'b1;
        for (int cy = 0; cy < 300 && npk < 8; cy++) begin
            @(negedge clk_mac);
            chk("t5_grant_range", grant3 < 2'd3, 1);
            oh3 = 3'(1) << ep;
            chk("t5_s_tready", s3_tready & ~oh3, 0);
            if (m3_tvalid && m3_tready) begin
                if (st) chk("t5_order", grant3, ep);
                e3 = {(cnt3[ep] % 3 == 2), 8'(ep * 16 + cnt3[ep])};
                chk("t5_byte", {m3_tlast, m3_tdata}, e3);
                if (cnt3[ep] % 3 == 2) begin
                    st = 1'b1;
                    npk++;
                    cnt3[ep]++;
                    ep = 3 - ep;
                end else begin
                    st = 1'b0;
                    cnt3[ep]++;
                end
            end
            @(posedge clk_mac);
            #1;
            for (int k = 1; k < 3; k++) begin
                s3_tdata[k*8 +: 8] = 8'(k * 16 + cnt3[k]);
                s3_tlast[k]        = (cnt3[k] % 3 == 2);
            end
        end
        chk("t5_npkts", npk, 8);
        s3_tvalid = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
